// File: rtl/ascon_fc_pkg.sv
// rtl/ascon_fc_pkg.sv - shared widths, session states and status codes for the FC session controller
package ascon_fc_pkg;

  localparam int FC_K       = 128;
  localparam int FC_L       = 40;
  localparam int FC_Y       = 40;
  localparam int FC_NONCE_W = 128;
  localparam int FC_TAG_W   = 128;

  localparam logic [1:0] ST_OK          = 2'd0;
  localparam logic [1:0] ST_AUTH_FAIL   = 2'd1;
  localparam logic [1:0] ST_PT_MISMATCH = 2'd2;
  localparam logic [1:0] ST_TIMEOUT     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENC_GO   = 3'd1,
    S_ENC_WAIT = 3'd2,
    S_DEC_GO   = 3'd3,
    S_DEC_WAIT = 3'd4,
    S_CHECK    = 3'd5,
    S_RESP     = 3'd6
  } state_e;

  // Round-trip verdict; a failed authentication outranks a plaintext mismatch.
  function automatic logic [1:0] check_status(input logic auth_ok, input logic pt_match);
    if (!auth_ok) begin
      return ST_AUTH_FAIL;
    end
    if (!pt_match) begin
      return ST_PT_MISMATCH;
    end
    return ST_OK;
  endfunction

endpackage

// File: rtl/fc_ready_edge.sv
// rtl/fc_ready_edge.sv - registered rising-edge detector for an FC ready flag, with arm input
module fc_ready_edge (
  input  logic clk,
  input  logic rst,
  input  logic arm_i,
  input  logic ready_i,
  output logic rise_o
);

  logic hist_q;

  // Remember last ready level; arming forces history high so a stale high level is not a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 1'b1;
    end else if (arm_i) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= ready_i;
    end
  end

  assign rise_o = ready_i & ~hist_q;

endmodule

// File: rtl/ascon_fc_session_ctrl.sv
// rtl/ascon_fc_session_ctrl.sv - FC encrypt/decrypt round-trip session controller (option: FC_SEQ_TIMEOUT_EN)
module ascon_fc_session_ctrl
  import ascon_fc_pkg::*;
#(
  parameter int K       = FC_K,
  parameter int L       = FC_L,
  parameter int Y       = FC_Y,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [K-1:0]          req_key,
  input  logic [FC_NONCE_W-1:0] req_nonce,
  input  logic [L-1:0]          req_ad,
  input  logic [Y-1:0]          req_pt,
  output logic [K-1:0]          fc_key,
  output logic [FC_NONCE_W-1:0] fc_nonce,
  output logic [L-1:0]          fc_ad,
  output logic [Y-1:0]          fc_pt,
  output logic                  fc_enc_start,
  output logic                  fc_dec_start,
  input  logic                  fc_enc_ready,
  input  logic                  fc_dec_ready,
  input  logic [Y-1:0]          fc_cipher,
  input  logic [FC_TAG_W-1:0]   fc_tag,
  input  logic [Y-1:0]          fc_dec_pt,
  input  logic                  fc_msg_auth,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [Y-1:0]          rsp_cipher,
  output logic [FC_TAG_W-1:0]   rsp_tag,
  output logic [1:0]            rsp_status
);

  state_e                state_q, state_d;
  logic [K-1:0]          key_q;
  logic [FC_NONCE_W-1:0] nonce_q;
  logic [L-1:0]          ad_q;
  logic [Y-1:0]          pt_q;
  logic [Y-1:0]          cipher_q;
  logic [FC_TAG_W-1:0]   tag_q;
  logic [1:0]            status_q;
  logic                  enc_rise, dec_rise, timeout;

  fc_ready_edge u_enc_edge (
    .clk     (clk),
    .rst     (rst),
    .arm_i   (state_q == S_ENC_GO),
    .ready_i (fc_enc_ready),
    .rise_o  (enc_rise)
  );

  fc_ready_edge u_dec_edge (
    .clk     (clk),
    .rst     (rst),
    .arm_i   (state_q == S_DEC_GO),
    .ready_i (fc_dec_ready),
    .rise_o  (dec_rise)
  );

`ifdef FC_SEQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q;

  // Watchdog reloaded on entry to each wait state, counting down while FC is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_ENC_GO || state_q == S_DEC_GO) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign timeout = (cnt_q == '0) &&
                   ((state_q == S_ENC_WAIT && !enc_rise) || (state_q == S_DEC_WAIT && !dec_rise));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
`endif

  // Session state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake/start strobes.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    fc_enc_start = 1'b0;
    fc_dec_start = 1'b0;
    rsp_valid    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_ENC_GO;
      end
      S_ENC_GO: begin
        fc_enc_start = 1'b1;
        state_d      = S_ENC_WAIT;
      end
      S_ENC_WAIT: begin
        if (enc_rise)     state_d = S_DEC_GO;
        else if (timeout) state_d = S_RESP;
      end
      S_DEC_GO: begin
        fc_dec_start = 1'b1;
        state_d      = S_DEC_WAIT;
      end
      S_DEC_WAIT: begin
        if (dec_rise)     state_d = S_CHECK;
        else if (timeout) state_d = S_RESP;
      end
      S_CHECK: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, result capture on encryption done, verdict in CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q    <= '0;
      nonce_q  <= '0;
      ad_q     <= '0;
      pt_q     <= '0;
      cipher_q <= '0;
      tag_q    <= '0;
      status_q <= ST_OK;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        key_q   <= req_key;
        nonce_q <= req_nonce;
        ad_q    <= req_ad;
        pt_q    <= req_pt;
      end
      if (state_q == S_ENC_WAIT && enc_rise) begin
        cipher_q <= fc_cipher;
        tag_q    <= fc_tag;
      end else if (timeout) begin
        cipher_q <= '0;
        tag_q    <= '0;
        status_q <= ST_TIMEOUT;
      end
      if (state_q == S_CHECK) begin
        status_q <= check_status(fc_msg_auth, fc_dec_pt == pt_q);
      end
    end
  end

  assign fc_key     = key_q;
  assign fc_nonce   = nonce_q;
  assign fc_ad      = ad_q;
  assign fc_pt      = pt_q;
  assign rsp_cipher = cipher_q;
  assign rsp_tag    = tag_q;
  assign rsp_status = status_q;

endmodule
